// File: rtl/uart_tx_scheduler.sv
// Two-requester byte scheduler feeding a UART transmitter: per-requester FIFOs,
// round-robin arbitration, and a launch/acknowledge handshake with timeout.
module uart_tx_scheduler #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] req0_data_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req1_data_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_start_o,
  input  logic              tx_busy_i,
  output logic              grant_id_o,
  output logic              start_err_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitAck, StWaitDone} state_e;

  logic [DATA_W-1:0] mem_q    [2][FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q [2];
  logic [PtrW-1:0]   rd_ptr_q [2];
  logic [CntW-1:0]   count_q  [2];
  logic [DATA_W-1:0] in_data  [2];
  logic [DATA_W-1:0] head     [2];
  logic [1:0]        in_valid;
  logic [1:0]        ready;
  logic [1:0]        nonempty;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic              sel;
  logic              pop_en;

  state_e            state_q;
  logic [TmoW-1:0]   tmo_q;
  logic [TmoW-1:0]   tmo_inc;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic              start_err_q;
  logic              grant_q;

  always_comb begin
    in_data[0]  = req0_data_i;
    in_data[1]  = req1_data_i;
    in_valid[0] = req0_valid_i;
    in_valid[1] = req1_valid_i;
    for (int i = 0; i < 2; i++) begin
      ready[i]    = count_q[i] < CntW'(FIFO_DEPTH);
      nonempty[i] = count_q[i] != '0;
      push[i]     = in_valid[i] & ready[i];
      head[i]     = mem_q[i][rd_ptr_q[i]];
    end
  end

  // Round-robin: with both queues occupied the requester not granted last wins.
  always_comb begin
    sel    = (&nonempty) ? ~grant_q : nonempty[1];
    pop_en = (state_q == StIdle) && !tx_busy_i && (|nonempty);
    pop[0] = pop_en & ~sel;
    pop[1] = pop_en & sel;
  end

  // Storage needs no reset; the pointers and counts define what is valid.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_data[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        if (push[i] && !pop[i]) begin
          count_q[i] <= count_q[i] + CntW'(1);
        end else if (pop[i] && !push[i]) begin
          count_q[i] <= count_q[i] - CntW'(1);
        end
      end
    end
  end

  assign tmo_inc = tmo_q + TmoW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      tmo_q       <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      start_err_q <= 1'b0;
      grant_q     <= 1'b1;
    end else begin
      tx_start_q  <= 1'b0;
      start_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop_en) begin
            tx_data_q  <= sel ? head[1] : head[0];
            grant_q    <= sel;
            tx_start_q <= 1'b1;
            state_q    <= StLaunch;
          end
        end
        StLaunch: begin
          tmo_q   <= '0;
          state_q <= StWaitAck;
        end
        StWaitAck: begin
          if (tx_busy_i) begin
            state_q <= StWaitDone;
          end else begin
            tmo_q <= tmo_inc;
            // No acknowledge in time: flag it and drop the byte.
            if (tmo_inc == TmoW'(ACK_TIMEOUT)) begin
              start_err_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
        end
        StWaitDone: begin
          if (!tx_busy_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req0_ready_o = ready[0];
  assign req1_ready_o = ready[1];
  assign tx_data_o    = tx_data_q;
  assign tx_start_o   = tx_start_q;
  assign grant_id_o   = grant_q;
  assign start_err_o  = start_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_scheduler;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic          r0, r1;
  logic [DW-1:0] tx_data;
  logic          tx_start, grant_id, start_err;
  logic          tx_busy = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx_scheduler #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_data_i(d0), .req0_valid_i(v0), .req0_ready_o(r0),
    .req1_data_i(d1), .req1_valid_i(v1), .req1_ready_o(r1),
    .tx_data_o(tx_data), .tx_start_o(tx_start), .tx_busy_i(tx_busy),
    .grant_id_o(grant_id), .start_err_o(start_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter stand-in: after tx_start, raise busy ack_delay cycles later for busy_len cycles.
  bit auto_mode = 1'b0, prev_auto = 1'b0;
  logic busy_force = 1'b0;
  int ack_delay = 2, busy_len = 10, tcnt = 0, blen = 0;
  always @(posedge clk) begin
    #2;
    if (auto_mode && !prev_auto) begin
      tcnt = 0;
      blen = 0;
    end
    prev_auto = auto_mode;
    if (tx_start) begin
      tcnt = ack_delay;
      blen = 0;
    end else if (tcnt > 0) begin
      tcnt--;
      if (tcnt == 0) blen = busy_len;
    end else if (blen > 0) begin
      blen--;
    end
    tx_busy = auto_mode ? (blen > 0) : busy_force;
  end

  // Reference model: queues per requester plus the launch/ack phase of the scheduler.
  logic [DW-1:0] mq0[$], mq1[$];
  int            m_phase = 0;  // 0 idle, 1 launching, 2 awaiting ack, 3 awaiting done
  int            m_wait = 0, pick = 0;
  bit            m_err = 0, m_grant = 1, m_valid = 0, p0 = 0, p1 = 0;
  logic [DW-1:0] m_txd = '0;

  always @(posedge clk) begin
    if (rst) begin
      mq0.delete();
      mq1.delete();
      m_phase = 0; m_wait = 0; m_err = 0; m_grant = 1; m_txd = '0; m_valid = 1;
    end else begin
      p0 = v0 && (mq0.size() < DEPTH);
      p1 = v1 && (mq1.size() < DEPTH);
      m_err = 0;
      case (m_phase)
        0: if (!tx_busy && (mq0.size() > 0 || mq1.size() > 0)) begin
          if (mq0.size() > 0 && mq1.size() > 0) pick = m_grant ? 0 : 1;
          else pick = (mq0.size() > 0) ? 0 : 1;
          if (pick == 0) m_txd = mq0.pop_front();
          else m_txd = mq1.pop_front();
          m_grant = (pick == 1);
          m_phase = 1;
        end
        1: begin m_phase = 2; m_wait = 0; end
        2: if (tx_busy) m_phase = 3;
           else begin
             m_wait++;
             if (m_wait == TMO) begin m_err = 1; m_phase = 0; end
           end
        default: if (!tx_busy) m_phase = 0;
      endcase
      if (p0) mq0.push_back(d0);
      if (p1) mq1.push_back(d1);
    end
  end

  logic [DW-1:0] log_d[$];
  bit            log_g[$];
  int            log_c[$];
  int            errs = 0, err_cyc = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("tx_start", tx_start, m_phase == 1);
      chk("start_err", start_err, m_err);
      chk("tx_data", tx_data, m_txd);
      chk("grant_id", grant_id, m_grant);
      chk("req0_ready", r0, mq0.size() < DEPTH);
      chk("req1_ready", r1, mq1.size() < DEPTH);
      if (tx_start) begin
        log_d.push_back(tx_data);
        log_g.push_back(grant_id);
        log_c.push_back(cyc);
      end
      if (start_err) begin
        errs++;
        err_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One reset cycle with junk pushes offered, which must be discarded.
  task automatic do_reset();
    tick(1);
    rst = 1; v0 = 1; v1 = 1; d0 = 8'hEE; d1 = 8'hEE;
    tick(1);
    rst = 0; v0 = 0; v1 = 0;
    chk("rst tx_data", tx_data, 0);
    chk("rst grant_id", grant_id, 1);
    chk("rst tx_start", tx_start, 0);
    chk("rst start_err", start_err, 0);
    chk("rst ready0", r0, 1);
    chk("rst ready1", r1, 1);
    log_d.delete(); log_g.delete(); log_c.delete();
    errs = 0;
  endtask

  task automatic push0(input logic [DW-1:0] b);
    v0 = 1; d0 = b; tick(1); v0 = 0;
  endtask

  task automatic chk_launch(input string name, input int idx, input logic [DW-1:0] d,
                            input bit g);
    if (idx < log_d.size()) begin
      chk({name, " data"}, log_d[idx], d);
      chk({name, " grant"}, log_g[idx], g);
    end else begin
      total++;
      bad++;
      $display("FAIL %s: launch %0d missing, got %0d launches", name, idx, log_d.size());
    end
  endtask

  task automatic set_auto(input int dly, input int len);
    ack_delay = dly; busy_len = len; auto_mode = 1;
  endtask

  task automatic set_manual(input logic b);
    auto_mode = 0; busy_force = b;
  endtask

  int pc;

  initial begin
    tick(2);
    // Single byte with latency check
    set_auto(2, 10);
    do_reset();
    push0(8'hA5);
    pc = cyc;
    tick(25);
    chk("single count", log_d.size(), 1);
    chk_launch("single", 0, 8'hA5, 0);
    chk("single errs", errs, 0);
    if (log_c.size() > 0) chk("single latency", log_c[0] - pc, 1);

    // Fairness with both FIFOs preloaded
    set_manual(1);
    do_reset();
    v0 = 1; v1 = 1; d0 = 8'h01; d1 = 8'h11; tick(1);
    d0 = 8'h02; d1 = 8'h12; tick(1);
    v0 = 0; v1 = 0; tick(2);
    set_auto(2, 3);
    tick(40);
    chk("fair count", log_d.size(), 4);
    chk_launch("fair0", 0, 8'h01, 0);
    chk_launch("fair1", 1, 8'h11, 1);
    chk_launch("fair2", 2, 8'h02, 0);
    chk_launch("fair3", 3, 8'h12, 1);

    // Full FIFO while transmitter is busy
    set_manual(1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v1 = 1; d1 = 8'h21 + 8'(i); tick(1);
    end
    chk("full ready1", r1, 0);
    d1 = 8'h25; tick(1); v1 = 0;
    chk("full ready1 hold", r1, 0);
    tick(2);
    set_auto(2, 2);
    tick(40);
    chk("full count", log_d.size(), 4);
    for (int i = 0; i < 4; i++) chk_launch("full", i, 8'h21 + 8'(i), 1);

    // Acknowledge timeout
    set_manual(0);
    do_reset();
    push0(8'h3C);
    tick(25);
    chk("tmo errs", errs, 1);
    chk("tmo count", log_d.size(), 1);
    if (log_c.size() > 0) chk("tmo timing", err_cyc - log_c[0], 17);
    set_auto(2, 3);
    push0(8'h3D);
    tick(15);
    chk_launch("tmo next", 1, 8'h3D, 0);
    chk("tmo errs after", errs, 1);

    // Reset while waiting for the transmitter to finish
    set_auto(2, 30);
    do_reset();
    for (int i = 0; i < 4; i++) push0(8'h41 + 8'(i));
    tick(5);
    set_manual(1);
    do_reset();
    tick(10);
    chk("midrst no launch busy", log_d.size(), 0);
    set_manual(0);
    tick(5);
    chk("midrst empty", log_d.size(), 0);

    // Push into a single-entry FIFO on its pop edge
    set_manual(1);
    do_reset();
    push0(8'h55);
    v0 = 1; d0 = 8'h66;
    set_auto(2, 3);
    tick(1);
    v0 = 0;
    chk("pp ready0", r0, 1);
    tick(20);
    chk("pp count", log_d.size(), 2);
    chk_launch("pp first", 0, 8'h55, 0);
    chk_launch("pp second", 1, 8'h66, 0);

    // Randomized traffic, checked by the per-cycle model comparison
    set_auto(2, 3);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) begin
        ack_delay = $urandom_range(1, 20);
        busy_len  = $urandom_range(1, 6);
      end
      v0  = ($urandom_range(0, 2) == 0);
      v1  = ($urandom_range(0, 2) == 0);
      d0  = DW'($urandom);
      d1  = DW'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    v0 = 0; v1 = 0; rst = 0;
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
